hotp_sample: RTL and testbench



---
 rtl/hotp_sample.sv | 133 +++++++++++++
 tb/tb_hotp_sample.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hotp_sample.sv
// HOTP dynamic truncation: picks a 31-bit word from a SHA-1 digest, reduces it
// modulo 1,000,000 by restoring division, then converts the remainder to 6 BCD digits.
module hotp_sample (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [159:0] sha1_digest,
  output logic [23:0]  code,
  output logic         ready
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOD  = 2'd1,
    ST_BCD  = 2'd2
  } state_t;

  localparam logic [20:0] MODULUS = 21'd1000000;

  // Double-dabble correction: any BCD nibble of 5 or more gets 3 added before the shift.
  function automatic logic [23:0] dabble_adjust(input logic [23:0] v);
    logic [23:0] r;
    r = v;
    for (int i = 0; i < 6; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t      state_q, state_d;
  logic [30:0] p_q, p_d;
  logic [19:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [23:0] bcd_q, bcd_d;
  logic [23:0] code_q, code_d;
  logic        ready_q, ready_d;

  logic [20:0] trial_s;
  logic [7:0]  base_s;
  logic [23:0] adj_s;
  logic        unused_s;

  // The upper nibble of the last byte can never be selected by a 4-bit offset.
  assign unused_s = ^sha1_digest[7:4];

  // Next-state and datapath: capture, one division step, or one dabble step per cycle.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    code_d  = code_q;
    ready_d = ready_q;
    trial_s = {rem_q, p_q[30]};
    // Bit 158 - 8*offset is bit 30 of the selected word, so bit 31 is dropped for free.
    base_s  = 8'd158 - {1'b0, sha1_digest[3:0], 3'b000};
    adj_s   = dabble_adjust(bcd_q);

    case (state_q)
      ST_IDLE: begin
        if (init) begin
          p_d     = sha1_digest[base_s -: 31];
          rem_d   = 20'd0;
          cnt_d   = 5'd0;
          bcd_d   = 24'd0;
          ready_d = 1'b0;
          state_d = ST_MOD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MOD: begin
        if (trial_s >= MODULUS) begin
          rem_d = trial_s[19:0] - MODULUS[19:0];
        end else begin
          rem_d = trial_s[19:0];
        end
        p_d = {p_q[29:0], 1'b0};
        if (cnt_q == 5'd30) begin
          cnt_d   = 5'd0;
          state_d = ST_BCD;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_BCD: begin
        if (cnt_q == 5'd20) begin
          code_d  = bcd_q;
          ready_d = 1'b1;
          cnt_d   = 5'd0;
          state_d = ST_IDLE;
        end else begin
          bcd_d = (adj_s << 1) | {23'd0, rem_q[19]};
          rem_d = {rem_q[18:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any computation and clears the code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      p_q     <= 31'd0;
      rem_q   <= 20'd0;
      cnt_q   <= 5'd0;
      bcd_q   <= 24'd0;
      code_q  <= 24'd0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      code_q  <= code_d;
      ready_q <= ready_d;
    end
  end

  assign code  = code_q;
  assign ready = ready_q;

endmodule

// File: tb/tb_hotp_sample.sv
// Scoreboard bench for hotp_sample: stimulus pushes expected codes, a monitor
// pops them on each ready rise and checks code, latency and code stability.
module tb_hotp_sample;

  logic         clk;
  logic         reset_n;
  logic         init;
  logic [159:0] sha1_digest;
  logic [23:0]  code;
  logic         ready;

  int           n_checks;
  int           n_errors;
  logic [23:0]  exp_q[$];
  logic [23:0]  last_code;

  localparam logic [159:0] D_RFC   = 160'h1f8698690e02ca16618550ef7f19da8e945b555a;
  localparam logic [159:0] D_CNT0  = 160'hcc93cf18508d94934c64b65d8ba7667fb7cde4b0;
  localparam logic [159:0] D_ONES  = {160{1'b1}};
  localparam logic [159:0] D_ZERO  = 160'd0;
  localparam logic [159:0] D_MAXR  = {32'h0, 32'h000F423F, 96'h4};
  localparam logic [159:0] D_WRAP  = {32'h0, 32'h000F4240, 96'h4};

  hotp_sample dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .init        (init),
    .sha1_digest (sha1_digest),
    .code        (code),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_level(input logic lvl, input int max_cycles, input string name);
    int n;
    n = 0;
    while (ready !== lvl && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(ready), 32'(lvl));
  endtask

  task automatic start(input logic [159:0] d, input logic [23:0] e);
    wait_level(1'b1, 200, "ready_before_start");
    sha1_digest = d;
    init        = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    init = 1'b0;
    check("ready_fall", 32'(ready), 32'd0);
    sha1_digest = ~d;
  endtask

  task automatic run(input logic [159:0] d, input logic [23:0] e);
    start(d, e);
    wait_level(1'b1, 100, "ready_rise");
  endtask

  // Monitor: latency, code held while busy, and scoreboard compare at each completion.
  initial begin
    int   busy;
    logic prev_ready;
    logic [23:0] e;
    busy       = 0;
    prev_ready = 1'b1;
    last_code  = 24'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        busy       = 0;
        prev_ready = 1'b1;
        last_code  = 24'd0;
      end else begin
        if (!ready) begin
          busy++;
          if (busy == 26) check("code_held_busy", 32'(code), 32'(last_code));
        end else if (!prev_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(code), 32'hFFFFFFFF);
          end else begin
            e = exp_q.pop_front();
            check("code", 32'(code), 32'(e));
            check("latency", 32'(busy), 32'd52);
            last_code = e;
          end
          busy = 0;
        end
        prev_ready = ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    n_checks    = 0;
    n_errors    = 0;
    reset_n     = 1'b0;
    init        = 1'b0;
    sha1_digest = 160'd0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_code", 32'(code), 32'd0);
    #3 reset_n = 1'b1;

    run(D_RFC,  24'h872921);
    run(D_CNT0, 24'h755224);
    run(D_ONES, 24'h483647);
    run(D_ZERO, 24'h000000);
    run(D_MAXR, 24'h999999);
    run(D_WRAP, 24'h000000);

    // init held high across completion restarts on the very next edge
    wait_level(1'b1, 200, "ready_before_hold");
    sha1_digest = D_MAXR;
    init        = 1'b1;
    exp_q.push_back(24'h999999);
    exp_q.push_back(24'h999999);
    @(negedge clk);
    wait_level(1'b1, 100, "hold_first_done");
    @(negedge clk);
    check("hold_restart", 32'(ready), 32'd0);
    init = 1'b0;
    wait_level(1'b1, 100, "hold_second_done");

    // init pulsed while busy is ignored
    start(D_RFC, 24'h872921);
    repeat (9) @(negedge clk);
    sha1_digest = D_CNT0;
    init        = 1'b1;
    @(negedge clk);
    init = 1'b0;
    wait_level(1'b1, 100, "busy_init_done");
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!ready) lows++;
    end
    check("no_second_run", 32'(lows), 32'd0);

    // asynchronous reset mid-computation
    start(D_ONES, 24'h483647);
    repeat (29) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_code", 32'(code), 32'd0);
    exp_q.delete();
    @(negedge clk);
    #3 reset_n = 1'b1;
    run(D_ONES, 24'h483647);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
